// File: rtl/crd_pkg.sv
// Shared definitions for the running-disparity lane checker:
// symbol width, lane FSM states and symbol weight classes.
package crd_pkg;

    localparam int SYM_W = 10;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        NEG     = 2'd1,
        POS     = 2'd2
    } crd_state_e;

    typedef enum logic [1:0] {
        W_NEG = 2'd0,
        W_NEU = 2'd1,
        W_POS = 2'd2,
        W_ILL = 2'd3
    } weight_e;

    // Only weights 4/5/6 are legal; everything else is a bad symbol.
    function automatic weight_e classify(input logic [SYM_W-1:0] sym);
        logic [3:0] ones;
        ones = '0;
        for (int i = 0; i < SYM_W; i++) begin
            ones = ones + {3'b000, sym[i]};
        end
        case (ones)
            4'd4:    return W_NEG;
            4'd5:    return W_NEU;
            4'd6:    return W_POS;
            default: return W_ILL;
        endcase
    endfunction

endpackage

// File: rtl/crd_lane.sv
// One lane of the disparity checker: tracks running disparity, flags
// symbol errors and drops lock after ERR_LIMIT consecutive errors.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   UNKNOWN | disparity not yet established (locked = 0)
//   NEG     | running disparity negative
//   POS     | running disparity positive (crd_bit = 1)
module crd_lane
    import crd_pkg::*;
#(
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [SYM_W-1:0] sym,
    output logic             crd_bit,
    output logic             err,
    output logic             locked,
    output logic             err_nxt
);

    localparam int ECW = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT) : 1;
    localparam logic [ECW-1:0] ECNT_TC = ECW'(ERR_LIMIT - 1);

    crd_state_e     state_q, state_d;
    logic [ECW-1:0] ecnt_q, ecnt_d;
    logic           err_q, err_d;
    weight_e        wclass;

    assign wclass = classify(sym);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= UNKNOWN;
            ecnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ecnt_q  <= ecnt_d;
            err_q   <= err_d;
        end
    end

    // A clean symbol always resets the run; errors never move the state
    // except when the run reaches its terminal count.
    always_comb begin
        state_d = state_q;
        ecnt_d  = ecnt_q;
        if (valid_in) begin
            if (err_d) begin
                if (ecnt_q == ECNT_TC) begin
                    state_d = UNKNOWN;
                    ecnt_d  = '0;
                end else begin
                    ecnt_d = ecnt_q + ECW'(1);
                end
            end else begin
                ecnt_d = '0;
                case (wclass)
                    W_NEG:   state_d = NEG;
                    W_POS:   state_d = POS;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        err_d = 1'b0;
        if (valid_in) begin
            case (state_q)
                UNKNOWN: err_d = (wclass == W_ILL);
                NEG:     err_d = (wclass == W_ILL) || (wclass == W_NEG);
                POS:     err_d = (wclass == W_ILL) || (wclass == W_POS);
                default: err_d = 1'b0;
            endcase
        end
    end

    assign crd_bit = (state_q == POS);
    assign locked  = (state_q != UNKNOWN);
    assign err     = err_q;
    assign err_nxt = err_d;

endmodule

// File: rtl/crd_lanes.sv
// Multi-lane running-disparity checker with a saturating aggregate
// error counter shared by all lanes.
module crd_lanes
    import crd_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [LANES*SYM_W-1:0] data_in,
    input  logic                   clear_cnt,
    output logic                   valid_out,
    output logic [LANES-1:0]       crd_bit,
    output logic [LANES-1:0]       err,
    output logic [LANES-1:0]       locked,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int POP_W = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LANES-1:0] err_nxt;
    logic [POP_W-1:0] pop;
    logic [CNT_W-1:0] cnt_base;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        crd_lane #(
            .ERR_LIMIT(ERR_LIMIT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .valid_in(valid_in),
            .sym     (data_in[k*SYM_W +: SYM_W]),
            .crd_bit (crd_bit[k]),
            .err     (err[k]),
            .locked  (locked[k]),
            .err_nxt (err_nxt[k])
        );
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++) begin
            pop = pop + POP_W'(err_nxt[k]);
        end
    end

    // A clear on a valid cycle still counts that cycle's errors.
    always_comb begin
        cnt_base = clear_cnt ? '0 : cnt_q;
        sum      = {{POP_W{1'b0}}, cnt_base} + {{CNT_W{1'b0}}, pop};
        cnt_d    = cnt_q;
        if (valid_in) begin
            cnt_d = (sum > {{POP_W{1'b0}}, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
        end else if (clear_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_in;
        end
    end

    assign err_cnt   = cnt_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_crd_lanes.sv
// Randomized and directed checks of crd_lanes against a disparity
// model based on symbol weight arithmetic.
module tb_crd_lanes;

    localparam int LANES     = 4;
    localparam int ERR_LIMIT = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = 15;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_in;
    logic [LANES*10-1:0] data_in;
    logic                clear_cnt;
    logic                valid_out;
    logic [LANES-1:0]    crd_bit;
    logic [LANES-1:0]    err;
    logic [LANES-1:0]    locked;
    logic [CNT_W-1:0]    err_cnt;

    crd_lanes #(
        .LANES    (LANES),
        .ERR_LIMIT(ERR_LIMIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .data_in  (data_in),
        .clear_cnt(clear_cnt),
        .valid_out(valid_out),
        .crd_bit  (crd_bit),
        .err      (err),
        .locked   (locked),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: disparity -1/0/+1 (0 = unknown), consecutive error run per lane
    int               m_rd[LANES];
    int               m_run[LANES];
    logic [LANES-1:0] m_err;
    logic             m_vout;
    int               m_cnt;

    localparam logic [9:0] S_POS  = 10'b0111011001;
    localparam logic [9:0] S_NEG  = 10'b1000101001;
    localparam logic [9:0] S_NEU  = 10'b0110101010;
    localparam logic [9:0] S_NEG2 = 10'b0110100100;
    localparam logic [9:0] S_ILL7 = 10'b1111111000;
    localparam logic [9:0] S_ILL0 = 10'b0000000000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LANES*10-1:0] pack4(input logic [9:0] s0, input logic [9:0] s1,
                                                  input logic [9:0] s2, input logic [9:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            m_rd[k]  = 0;
            m_run[k] = 0;
        end
        m_err  = '0;
        m_vout = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic v, input logic [LANES*10-1:0] d, input logic c);
        int w;
        int nerr;
        logic [9:0] s;
        nerr = 0;
        for (int k = 0; k < LANES; k++) begin
            m_err[k] = 1'b0;
            if (v) begin
                s = d[10*k +: 10];
                w = $countones(s) - 5;
                if (w < -1 || w > 1) m_err[k] = 1'b1;
                else if (w != 0 && w == m_rd[k]) m_err[k] = 1'b1;
                else if (w != 0) m_rd[k] = w;
                if (m_err[k]) begin
                    m_run[k]++;
                    nerr++;
                    if (m_run[k] == ERR_LIMIT) begin
                        m_rd[k]  = 0;
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
        if (v) m_cnt = ((c ? 0 : m_cnt) + nerr > CNT_MAX) ? CNT_MAX : (c ? 0 : m_cnt) + nerr;
        else if (c) m_cnt = 0;
        m_vout = v;
    endtask

    task automatic check_all(input string tag);
        logic [LANES-1:0] ecrd;
        logic [LANES-1:0] elock;
        for (int k = 0; k < LANES; k++) begin
            ecrd[k]  = (m_rd[k] == 1);
            elock[k] = (m_rd[k] != 0);
        end
        chk({tag, ".crd"}, crd_bit, ecrd);
        chk({tag, ".err"}, err, m_err);
        chk({tag, ".locked"}, locked, elock);
        chk({tag, ".vout"}, valid_out, m_vout);
        chk({tag, ".cnt"}, err_cnt, m_cnt);
    endtask

    task automatic step(input string tag, input logic v, input logic [LANES*10-1:0] d, input logic c);
        @(negedge clk);
        valid_in  = v;
        data_in   = d;
        clear_cnt = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check_all(tag);
    endtask

    function automatic logic [9:0] rsym();
        int r;
        int w;
        int ill[8];
        logic [9:0] s;
        ill = '{0, 1, 2, 3, 7, 8, 9, 10};
        r = $urandom_range(9, 0);
        if (r < 3) w = 4;
        else if (r < 6) w = 6;
        else if (r < 8) w = 5;
        else w = ill[$urandom_range(7, 0)];
        s = '0;
        while ($countones(s) != w) s[$urandom_range(9, 0)] = 1'b1;
        return s;
    endfunction

    // reset asserted between edges must clear outputs with no clock edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = pack4(rsym(), rsym(), rsym(), rsym());
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".now"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst      = 1'b1;
        valid_in = 1'b0;
    endtask

    initial begin
        int exp_sat[5];
        logic v;
        logic c;
        exp_sat = '{4, 8, 12, 15, 15};

        rst       = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        clear_cnt = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        #2;
        chk("rst.crd", crd_bit, 0);
        chk("rst.err", err, 0);
        chk("rst.locked", locked, 0);
        chk("rst.vout", valid_out, 0);
        chk("rst.cnt", err_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // positive then negative symbol on lane0
        step("r29a", 1'b1, pack4(S_POS, S_NEU, S_NEU, S_NEU), 1'b0);
        chk("r29a.crd0", crd_bit[0], 1);
        chk("r29a.lock0", locked[0], 1);
        chk("r29a.err0", err[0], 0);
        step("r29b", 1'b1, pack4(S_NEG, S_NEU, S_NEU, S_NEU), 1'b0);
        chk("r29b.crd0", crd_bit[0], 0);
        chk("r29b.err0", err[0], 0);

        // repeated positive is a disparity error
        step("r30a", 1'b1, pack4(S_POS, S_NEU, S_NEU, S_NEU), 1'b0);
        step("r30b", 1'b1, pack4(S_POS, S_NEU, S_NEU, S_NEU), 1'b0);
        chk("r30.err0", err[0], 1);
        chk("r30.crd0", crd_bit[0], 1);
        chk("r30.cnt", err_cnt, 1);

        // lane1 in NEG, four illegal symbols drop its lock
        step("r31n", 1'b1, pack4(S_NEU, S_NEG, S_NEU, S_NEU), 1'b0);
        chk("r31n.lock1", locked[1], 1);
        for (int i = 0; i < 4; i++) begin
            step("r31", 1'b1, pack4(S_NEU, S_ILL7, S_NEU, S_NEU), 1'b0);
            chk("r31.err", err, 4'b0010);
            if (i == 2) chk("r31.lock1_3rd", locked[1], 1);
        end
        chk("r31.lock1", locked[1], 0);
        chk("r31.lock0", locked[0], 1);
        chk("r31.crd0", crd_bit[0], 1);
        chk("r31.cnt", err_cnt, 5);

        // neutral leaves lane2 unknown, then negative locks it
        step("r32a", 1'b1, pack4(S_NEU, S_NEU, S_NEU, S_NEU), 1'b0);
        chk("r32a.lock2", locked[2], 0);
        chk("r32a.err2", err[2], 0);
        step("r32b", 1'b1, pack4(S_NEU, S_NEU, S_NEG2, S_NEU), 1'b0);
        chk("r32b.lock2", locked[2], 1);
        chk("r32b.crd2", crd_bit[2], 0);

        // valid gap holds state with no errors
        step("gap", 1'b0, pack4(S_ILL0, S_ILL0, S_ILL0, S_ILL0), 1'b0);
        chk("gap.err", err, 0);
        chk("gap.vout", valid_out, 0);
        chk("gap.crd", crd_bit, 4'b0001);
        chk("gap.locked", locked, 4'b0101);

        async_reset("r34");
        chk("r34.locked", locked, 0);
        chk("r34.cnt", err_cnt, 0);

        // saturation of a 4-bit counter, then clear during errors
        for (int i = 0; i < 5; i++) begin
            step("r33s", 1'b1, pack4(S_ILL0, S_ILL0, S_ILL0, S_ILL0), 1'b0);
            chk("r33.sat", err_cnt, exp_sat[i]);
        end
        step("r33c", 1'b1, pack4(S_ILL0, S_ILL7, S_NEU, S_NEU), 1'b1);
        chk("r33.clr", err_cnt, 2);
        step("clr_idle", 1'b0, '0, 1'b1);
        chk("clr_idle.cnt", err_cnt, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(59, 0) == 0) begin
                async_reset("rnd_rst");
            end else begin
                v = ($urandom_range(3, 0) != 0);
                c = ($urandom_range(15, 0) == 0);
                step("rnd", v, pack4(rsym(), rsym(), rsym(), rsym()), c);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crd_lanes.md
CRD_LANES -- requirements
Module: crd_lanes

Interface
REQ-001 SHALL provide parameter LANES, default 4, number of independent 10-bit symbol lanes (1..16).
REQ-002 SHALL provide parameter ERR_LIMIT, default 4, consecutive per-lane errors that force loss of disparity lock (1..15).
REQ-003 SHALL provide parameter CNT_W, default 16, width of the aggregate error counter.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 valid_in  input  1  data_in carries one symbol per lane this cycle.
REQ-007 data_in  input  LANES*10  lane k symbol at bits [10k+9:10k].
REQ-008 clear_cnt  input  1  synchronous clear of err_cnt.
REQ-009 valid_out  output  1  registered copy of valid_in.
REQ-010 crd_bit  output  LANES  per-lane running disparity, 1 = positive.
REQ-011 err  output  LANES  per-lane error pulse for the symbol just checked.
REQ-012 locked  output  LANES  per-lane disparity known.
REQ-013 err_cnt  output  CNT_W  saturating total of err bits asserted.

Function
REQ-014 Each lane SHALL classify a symbol by ones-count: 4 = negative, 5 = neutral, 6 = positive, any other = illegal weight.
REQ-015 Each lane SHALL run an FSM with states UNKNOWN, NEG, POS; crd_bit = 1 only in POS; locked = 0 only in UNKNOWN.
REQ-016 In UNKNOWN: positive -> POS, negative -> NEG, neutral -> stay UNKNOWN, all without err; illegal -> err, stay UNKNOWN.
REQ-017 In NEG: positive -> POS no err; neutral -> NEG no err; negative -> err, stay NEG; illegal -> err, stay NEG.
REQ-018 In POS: negative -> NEG no err; neutral -> POS no err; positive -> err, stay POS; illegal -> err, stay POS.
REQ-019 Each lane SHALL count consecutive errors; a clean symbol resets the count; the ERR_LIMIT-th consecutive error SHALL assert err and move the lane to UNKNOWN in the same update.
REQ-020 Latency SHALL be one cycle: symbol sampled at edge N, crd_bit/err/locked/valid_out updated at edge N and visible until edge N+1.
REQ-021 When valid_in = 0, lane state and consecutive counts SHALL hold, err SHALL be 0, valid_out SHALL be 0.
REQ-022 err_cnt SHALL add popcount(err-next) each valid cycle and saturate at 2^CNT_W-1 without wrap.
REQ-023 clear_cnt with a concurrent valid cycle SHALL load err_cnt with that cycle's popcount, not zero.
REQ-024 Lanes SHALL be fully independent; an error in one lane SHALL not affect any other lane's state.

Reset
REQ-025 rst low SHALL immediately force all lanes to UNKNOWN, consecutive counts to 0, crd_bit/err/locked/valid_out/err_cnt to 0.
REQ-026 rst deassertion mid-stream SHALL restart every lane from UNKNOWN; the first valid symbol after reset follows REQ-016.

Structure
REQ-027 Shared package crd_pkg SHALL hold SYM_W = 10, the state enum (UNKNOWN, NEG, POS) and the weight-class enum (W_NEG, W_NEU, W_POS, W_ILL).
REQ-028 Per-lane FSM and consecutive-error counter SHALL be sub-module crd_lane, instantiated LANES times in a generate loop; the err_cnt adder stays in crd_lanes.

Verification
REQ-029 Reset, lane0 0111011001 (6 ones) then 1000101001 (4 ones) -> crd_bit[0] 1 then 0, err[0] 0, locked[0] 1 from first symbol.
REQ-030 Lane0 in POS, send 0111011001 twice -> second cycle err[0]=1, crd_bit[0]=1, err_cnt increments by 1.
REQ-031 Lane1 in NEG, send 1111111000 (7 ones) four times, ERR_LIMIT=4 -> err[1]=1 each cycle, locked[1]=0 after the fourth, other lanes unchanged.
REQ-032 Lane2 from reset, 0110101010 (neutral) -> locked[2]=0, err[2]=0; then 0110100100 -> locked[2]=1, crd_bit[2]=0.
REQ-033 CNT_W=4, all 4 lanes erroring for 5 valid cycles -> err_cnt saturates at 15; clear_cnt with 2 lanes erroring -> err_cnt=2.
REQ-034 Assert rst low mid-stream between edges -> all outputs 0 immediately, without a clock edge; valid_in=0 gaps hold state with err=0.
